// File: rtl/vga_frame_capture.sv
// vga_frame_capture
// Receive side of the VGA image path. Rebuilds pixel/line position from the
// hsync/vsync/RGB stream on the system clock, captures the 64x64 image window
// into a 4096x12 buffer, and keeps a running 24-bit checksum of what it stored.
// The buffer has a synchronous readback port for in-system or bench checking.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for arm; buffer and checksum hold the last capture
// ARMED   | arm accepted, waiting for vsync rising edge (frame start)
// CAPTURE | storing window pixels, accumulating checksum and pixel count
// DONE    | single cycle: frame_done pulse, busy dropped, back to IDLE

module vga_frame_capture #(
    parameter int CLKS_PER_PIXEL = 4,
    parameter int SAMPLE_PHASE   = 2,
    parameter int H_OFS          = 48,
    parameter int V_OFS          = 33,
    parameter int IMG_X0         = 288,
    parameter int IMG_Y0         = 208,
    parameter int SCALE          = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    input  logic        arm,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic [23:0] checksum,
    input  logic [11:0] rd_addr,
    output logic [11:0] rd_data
);

    // A one-clock pixel still needs a 1-bit phase register, it just never moves.
    localparam int PH_W  = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
    localparam int SC_SH = $clog2(SCALE);

    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLKS_PER_PIXEL - 1);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_PHASE);

    // Positions are carried as 12-bit signed so that the blanking region
    // before the visible area comes out negative and can never hit.
    localparam logic signed [11:0] H_OFS_S = 12'(H_OFS);
    localparam logic signed [11:0] V_OFS_S = 12'(V_OFS);
    localparam logic signed [11:0] X0_S    = 12'(IMG_X0);
    localparam logic signed [11:0] Y0_S    = 12'(IMG_Y0);
    localparam logic signed [11:0] WIN_S   = 12'(64 * SCALE);
    localparam logic [11:0]        SC_MASK = 12'(SCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } state_t;

    state_t state;

    logic        s1_hs;
    logic        s1_vs;
    logic [11:0] s1_rgb;
    logic        s2_hs;
    logic        s2_vs;
    logic        hs_rise;
    logic        vs_rise;

    logic [PH_W-1:0] phase;
    logic [9:0]      hpix;
    logic [9:0]      vline;

    logic signed [11:0] x_pos;
    logic signed [11:0] y_pos;
    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic               x_in;
    logic               y_in;
    logic               x_aligned;
    logic               y_aligned;
    logic               hit;
    logic [11:0]        wr_addr;
    logic               wr_en;

    logic [12:0] pix_cnt;
    logic [11:0] mem [0:4095];

    assign hs_rise = s1_hs & ~s2_hs;
    assign vs_rise = s1_vs & ~s2_vs;

    // Window decode, evaluated on the registered counters and s1 data.
    assign x_pos = $signed({2'b00, hpix}) - H_OFS_S;
    assign y_pos = $signed({2'b00, vline}) - V_OFS_S;
    assign dx    = x_pos - X0_S;
    assign dy    = y_pos - Y0_S;

    assign x_in = (x_pos >= X0_S) && (dx < WIN_S);
    assign y_in = (y_pos >= Y0_S) && (dy < WIN_S);

    // With SCALE a power of two, "multiple of SCALE" is just the low bits clear.
    assign x_aligned = (($unsigned(dx) & SC_MASK) == 12'd0);
    assign y_aligned = (($unsigned(dy) & SC_MASK) == 12'd0);

    assign hit = (phase == PH_SAMPLE) && x_in && y_in && x_aligned && y_aligned;

    assign wr_addr = {dy[SC_SH +: 6], dx[SC_SH +: 6]};
    assign wr_en   = (state == CAPTURE) && hit && !rst;

    // Two-stage input register: s1 feeds data, s1/s2 together give sync edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_rgb <= 12'd0;
            s2_hs  <= 1'b0;
            s2_vs  <= 1'b0;
        end else begin
            s1_hs  <= hsync;
            s1_vs  <= vsync;
            s1_rgb <= {red, green, blue};
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
        end
    end

    // Pixel position: phase within a pixel and pixel count since hsync end.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            hpix  <= 10'd0;
        end else if (hs_rise) begin
            phase <= '0;
            hpix  <= 10'd0;
        end else if (phase == PH_LAST) begin
            phase <= '0;
            if (hpix != 10'd1023) begin
                hpix <= hpix + 10'd1;
            end
        end else begin
            phase <= phase + PH_W'(1);
        end
    end

    // Line position: lines since vsync end; vsync edge wins over hsync edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vline <= 10'd0;
        end else if (vs_rise) begin
            vline <= 10'd0;
        end else if (hs_rise && (vline != 10'd1023)) begin
            vline <= vline + 10'd1;
        end
    end

    // Capture sequencer with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            checksum   <= 24'd0;
            pix_cnt    <= 13'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state     <= ARMED;
                        busy      <= 1'b1;
                        frame_err <= 1'b0;
                        checksum  <= 24'd0;
                        pix_cnt   <= 13'd0;
                    end
                end
                ARMED: begin
                    // Hits here are ignored so a frame already in flight is never taken.
                    if (vs_rise) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (hit) begin
                        checksum <= checksum + {12'd0, s1_rgb};
                        pix_cnt  <= pix_cnt + 13'd1;
                    end
                    if (hit && (pix_cnt == 13'd4095)) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else if (vs_rise) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        frame_err  <= 1'b1;
                    end
                end
                DONE: begin
                    // arm in this cycle is deliberately dropped.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Image buffer write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= s1_rgb;
        end
    end

    // Readback port, one-cycle latency, read-before-write on a shared address.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 12'd0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
